// File: rtl/ramarb_pkg.sv
// Shared types and defaults for the SRAM arbiter.
// The state encoding is shared by the FSM and anything that decodes it.
package ramarb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int TMR_W      = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_WAIT  = 3'd1;
  localparam logic [2:0] ST_RD_CAP   = 3'd2;
  localparam logic [2:0] ST_WR_PULSE = 3'd3;
  localparam logic [2:0] ST_WR_HOLD  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_RD_WAIT  = ST_RD_WAIT,
    S_RD_CAP   = ST_RD_CAP,
    S_WR_PULSE = ST_WR_PULSE,
    S_WR_HOLD  = ST_WR_HOLD
  } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester, diag and SRAM signal bundle for the arbiter.
// slave is the arbiter side, master is the surrounding system.
interface ram_arbiter_if
  import ramarb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              cpu_halted;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              diag_req;
  logic              diag_we;
  logic [ADDR_W-1:0] diag_addr;
  logic [DATA_W-1:0] diag_wdata;
  logic [DATA_W-1:0] diag_rdata;
  logic              diag_ack;
  logic              grant_diag;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_cs;
  logic              ram_we;

  modport slave (
    input  cpu_halted, cpu_req, cpu_we,
    input  cpu_addr, cpu_wdata,
    input  diag_req, diag_we,
    input  diag_addr, diag_wdata,
    input  ram_rdata,
    output cpu_rdata, cpu_ack,
    output diag_rdata, diag_ack,
    output grant_diag,
    output ram_addr, ram_wdata,
    output ram_cs, ram_we
  );

  modport master (
    output cpu_halted, cpu_req, cpu_we,
    output cpu_addr, cpu_wdata,
    output diag_req, diag_we,
    output diag_addr, diag_wdata,
    output ram_rdata,
    input  cpu_rdata, cpu_ack,
    input  diag_rdata, diag_ack,
    input  grant_diag,
    input  ram_addr, ram_wdata,
    input  ram_cs, ram_we
  );

endinterface

// File: rtl/ram_cycle_timer.sv
// Loadable down-counter pacing SRAM read wait and write pulse.
// done is high whenever the count has reached zero.
module ram_cycle_timer
  import ramarb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ram_arbiter.sv
// Shares one SRAM between CPU and SPI diag engine: CPU priority,
// diag starvation guard, sequenced cs/we timing, 1-cycle ack.
module ram_arbiter
  import ramarb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int RD_WAIT       = 1,
  parameter int WR_PULSE      = 1,
  parameter int DIAG_MAX_WAIT = 64
) (
  input logic          fpga_clk,
  input logic          fpga_reset,
  ram_arbiter_if.slave bus
);

  localparam int WAIT_W = $clog2(DIAG_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX =
    WAIT_W'(DIAG_MAX_WAIT);
  localparam logic [TMR_W-1:0] RD_LOAD = TMR_W'(RD_WAIT - 1);
  localparam logic [TMR_W-1:0] WR_LOAD = TMR_W'(WR_PULSE);

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] crd_q, crd_n;
  logic [DATA_W-1:0] drd_q, drd_n;
  logic              cs_q, cs_n;
  logic              we_q, we_n;
  logic              gnt_q, gnt_n;
  logic              cack_q, cack_n;
  logic              dack_q, dack_n;
  logic              wr_q, wr_n;

  logic             go, starve, pick_d, win_we;
  logic             tmr_load, tmr_done;
  logic             d_serv, d_win;
  logic [TMR_W-1:0] tmr_val;

  assign go       = bus.cpu_req | bus.diag_req;
  assign starve   = bus.diag_req & (wait_cnt == WAIT_MAX);
  assign pick_d   = bus.diag_req &
                    (bus.cpu_halted | starve | ~bus.cpu_req);
  assign win_we   = pick_d ? bus.diag_we : bus.cpu_we;
  assign tmr_load = (state == S_IDLE) & go;
  assign tmr_val  = win_we ? WR_LOAD : RD_LOAD;
  assign d_serv   = (state != S_IDLE) & gnt_q;
  assign d_win    = tmr_load & pick_d;

  ram_cycle_timer u_tmr (
    .clk      (fpga_clk),
    .rst_n    (fpga_reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    crd_n   = crd_q;
    drd_n   = drd_q;
    cs_n    = cs_q;
    we_n    = we_q;
    gnt_n   = gnt_q;
    wr_n    = wr_q;
    cack_n  = 1'b0;
    dack_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go) begin
          addr_n  = pick_d ? bus.diag_addr : bus.cpu_addr;
          wdata_n = pick_d ? bus.diag_wdata : bus.cpu_wdata;
          wr_n    = win_we;
          gnt_n   = pick_d;
          cs_n    = 1'b1;
          state_n = win_we ? S_WR_PULSE : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (tmr_done) state_n = S_RD_CAP;
      end
      S_RD_CAP: begin
        if (gnt_q) drd_n = bus.ram_rdata;
        else       crd_n = bus.ram_rdata;
        dack_n  = gnt_q;
        cack_n  = ~gnt_q;
        cs_n    = 1'b0;
        state_n = S_IDLE;
      end
      // first cycle here is address setup with we low
      S_WR_PULSE: begin
        we_n = ~tmr_done;
        if (tmr_done) state_n = S_WR_HOLD;
      end
      S_WR_HOLD: begin
        dack_n  = gnt_q;
        cack_n  = ~gnt_q;
        cs_n    = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    wait_n = wait_cnt;
    if (!bus.diag_req || d_win) begin
      wait_n = '0;
    end else if (!d_serv && wait_cnt != WAIT_MAX) begin
      wait_n = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (!fpga_reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      crd_q    <= '0;
      drd_q    <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      cack_q   <= 1'b0;
      dack_q   <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      crd_q    <= crd_n;
      drd_q    <= drd_n;
      cs_q     <= cs_n;
      we_q     <= we_n;
      gnt_q    <= gnt_n;
      wr_q     <= wr_n;
      cack_q   <= cack_n;
      dack_q   <= dack_n;
    end
  end

  assign bus.ram_addr   = addr_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.ram_cs     = cs_q;
  assign bus.ram_we     = we_q;
  assign bus.grant_diag = gnt_q;
  assign bus.cpu_rdata  = crd_q;
  assign bus.diag_rdata = drd_q;
  assign bus.cpu_ack    = cack_q;
  assign bus.diag_ack   = dack_q;

endmodule
